vram_arbiter: RTL and testbench



---
 rtl/vram_arbiter_if.sv | 50 +++++
 rtl/vram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if
//   Bundles every signal of the VRAM arbiter except clock and reset.
//   - Client side: req/wr/be/addr/wdata in, ack/rdata/grant_id/busy out.
//     All per-client vectors are flattened, with client i in slice i.
//   - VRAM side: active-low strobes, address, write data with its tri-state
//     enable, and the sampled read data vram_data_in.
//   Modports:
//   - slave  : seen by the arbiter itself.
//   - master : seen by everything around it (clients plus the VRAM pins).
interface vram_arbiter_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int GW = $clog2(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0]            req;
  logic [NUM_CLIENTS-1:0]            wr;
  logic [NUM_CLIENTS*BW-1:0]         be;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_CLIENTS-1:0]            ack;
  logic [DATA_WIDTH-1:0]             rdata;
  logic [GW-1:0]                     grant_id;
  logic                              busy;

  logic                              _vram_en;
  logic                              _vram_rd;
  logic                              _vram_wr;
  logic [BW-1:0]                     _vram_be;
  logic [ADDR_WIDTH-1:0]             vram_addr;
  logic [DATA_WIDTH-1:0]             vram_data_out;
  logic                              vram_data_oe;
  logic [DATA_WIDTH-1:0]             vram_data_in;

  modport slave (
    input  req, wr, be, addr, wdata, vram_data_in,
    output ack, rdata, grant_id, busy,
           _vram_en, _vram_rd, _vram_wr, _vram_be,
           vram_addr, vram_data_out, vram_data_oe
  );

  modport master (
    output req, wr, be, addr, wdata, vram_data_in,
    input  ack, rdata, grant_id, busy,
           _vram_en, _vram_rd, _vram_wr, _vram_be,
           vram_addr, vram_data_out, vram_data_oe
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Serialises request/acknowledge transactions from NUM_CLIENTS masters onto
//   one active-low external VRAM bus. Each access takes WAIT_STATES+1 ACCESS
//   cycles followed by one RELEASE (turnaround) cycle in which the client is
//   acked. Arbitration is fixed priority (lowest index) or round-robin.
//   Ports:
//   - clk   : system clock
//   - reset : asynchronous reset, active high
//   - bus   : vram_arbiter_if.slave (client handshake + VRAM pins)
module vram_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 1,
  parameter int RR_MODE     = 0
) (
  input  logic          clk,
  input  logic          reset,
  vram_arbiter_if.slave bus
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int GW = $clog2(NUM_CLIENTS);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          gid_q, gid_d;
  logic [GW-1:0]          last_q, last_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  // Transaction captured at grant time
  logic                   wr_q, wr_d;
  logic [BW-1:0]          be_q, be_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

  // Registered VRAM pins
  logic                   en_q, en_d;
  logic                   rd_q, rd_d;
  logic                   vwr_q, vwr_d;
  logic [BW-1:0]          vbe_q, vbe_d;
  logic [ADDR_WIDTH-1:0]  vaddr_q, vaddr_d;
  logic [DATA_WIDTH-1:0]  vdout_q, vdout_d;
  logic                   oe_q, oe_d;

  logic [NUM_CLIENTS-1:0] ack_vec;
  logic [NUM_CLIENTS-1:0] elig;
  logic                   found;
  logic [GW-1:0]          win;
  logic [GW-1:0]          idx;
  int                     t;

  // The client acked in RELEASE is excluded from that cycle's arbitration, so
  // a req it has not yet dropped cannot start a duplicate access.
  always_comb begin
    ack_vec = '0;
    if (state_q == RELEASE) ack_vec[gid_q] = 1'b1;
  end

  always_comb begin
    elig  = bus.req & ~ack_vec;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    t     = 0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (RR_MODE != 0) begin
        // Search begins just past the last winner and wraps once.
        t = int'(last_q) + 1 + k;
        if (t >= NUM_CLIENTS) t = t - NUM_CLIENTS;
        idx = GW'(t);
      end else begin
        idx = GW'(k);
      end
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      IDLE, RELEASE: begin
        if (found) begin
          state_d = ACCESS;
          gid_d   = win;
          last_d  = win;
          cnt_d   = '0;
          wr_d    = bus.wr[win];
          be_d    = bus.be[win*BW +: BW];
          addr_d  = bus.addr[win*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = bus.wdata[win*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'(WAIT_STATES)) begin
          state_d = RELEASE;
          if (!wr_q) rdata_d = bus.vram_data_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pins are computed from the next state so they are registered yet line
    // up exactly with the ACCESS cycles. Address and write data keep their
    // last value outside an access.
    en_d    = 1'b1;
    rd_d    = 1'b1;
    vwr_d   = 1'b1;
    vbe_d   = '1;
    vaddr_d = vaddr_q;
    vdout_d = vdout_q;
    oe_d    = 1'b0;
    if (state_d == ACCESS) begin
      en_d    = 1'b0;
      rd_d    = wr_d;
      vwr_d   = ~wr_d;
      vbe_d   = ~be_d;
      vaddr_d = addr_d;
      if (wr_d) begin
        vdout_d = wdata_d;
        oe_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gid_q   <= '0;
      last_q  <= GW'(NUM_CLIENTS - 1);
      cnt_q   <= '0;
      rdata_q <= '0;
      en_q    <= 1'b1;
      rd_q    <= 1'b1;
      vwr_q   <= 1'b1;
      vbe_q   <= '1;
      vaddr_q <= '0;
      vdout_q <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      rd_q    <= rd_d;
      vwr_q   <= vwr_d;
      vbe_q   <= vbe_d;
      vaddr_q <= vaddr_d;
      vdout_q <= vdout_d;
      oe_q    <= oe_d;
    end
  end

  // Transaction latches are only read while ACCESS, which is always entered
  // through a grant that loads them, so they need no reset.
  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    be_q    <= be_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign bus.ack           = ack_vec;
  assign bus.rdata         = rdata_q;
  assign bus.grant_id      = gid_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus._vram_en      = en_q;
  assign bus._vram_rd      = rd_q;
  assign bus._vram_wr      = vwr_q;
  assign bus._vram_be      = vbe_q;
  assign bus.vram_addr     = vaddr_q;
  assign bus.vram_data_out = vdout_q;
  assign bus.vram_data_oe  = oe_q;
endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: fixed priority, 2 clients, 1 wait state
  // B: round-robin, 3 clients, 1 wait state
  // C: fixed priority, 2 clients, 0 wait states
  vram_arbiter_if #(.NUM_CLIENTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16)) ifa ();
  vram_arbiter_if #(.NUM_CLIENTS(3), .ADDR_WIDTH(16), .DATA_WIDTH(16)) ifb ();
  vram_arbiter_if #(.NUM_CLIENTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16)) ifc ();

  vram_arbiter #(.NUM_CLIENTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16),
                 .WAIT_STATES(1), .RR_MODE(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  vram_arbiter #(.NUM_CLIENTS(3), .ADDR_WIDTH(16), .DATA_WIDTH(16),
                 .WAIT_STATES(1), .RR_MODE(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  vram_arbiter #(.NUM_CLIENTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16),
                 .WAIT_STATES(0), .RR_MODE(0)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  typedef struct packed {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] din;
    logic        en;
    logic        rd;
    logic        wrs;
    logic [1:0]  vbe;
    logic [15:0] vaddr;
    logic [15:0] dout;
    logic        oe;
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic        busy;
    logic        gid;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int onehot_idx(input logic [2:0] v);
    int r;
    r = 7;
    if (v == 3'b001) r = 0;
    if (v == 3'b010) r = 1;
    if (v == 3'b100) r = 2;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack;
    int idle_seen;
    int got [4];
    int cyc [4];
    int exp_rr [4];
    exp_rr = '{0, 1, 2, 0};

    // Row = inputs applied before an edge, expected outputs after it.
    // Rows 0-3: client 1 reads 0x1234, VRAM returns 0xBEEF.
    // Rows 4-7: client 0 writes 0xA5A5 to 0x0800 with be=2'b10.
    vecs[0] = '{2'b10, 2'b00, 4'b1100, 32'h1234_0000, 32'h0, 16'hBEEF,
                1'b0, 1'b0, 1'b1, 2'b00, 16'h1234, 16'h0000, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b1};
    vecs[1] = vecs[0];
    vecs[2] = '{2'b10, 2'b00, 4'b1100, 32'h1234_0000, 32'h0, 16'hBEEF,
                1'b1, 1'b1, 1'b1, 2'b11, 16'h1234, 16'h0000, 1'b0, 2'b10, 16'hBEEF, 1'b1, 1'b1};
    vecs[3] = '{2'b00, 2'b00, 4'b1100, 32'h1234_0000, 32'h0, 16'h1111,
                1'b1, 1'b1, 1'b1, 2'b11, 16'h1234, 16'h0000, 1'b0, 2'b00, 16'hBEEF, 1'b0, 1'b1};
    vecs[4] = '{2'b01, 2'b01, 4'b0010, 32'h0000_0800, 32'h0000_A5A5, 16'h1111,
                1'b0, 1'b1, 1'b0, 2'b01, 16'h0800, 16'hA5A5, 1'b1, 2'b00, 16'hBEEF, 1'b1, 1'b0};
    vecs[5] = vecs[4];
    vecs[6] = '{2'b01, 2'b01, 4'b0010, 32'h0000_0800, 32'h0000_A5A5, 16'h1111,
                1'b1, 1'b1, 1'b1, 2'b11, 16'h0800, 16'hA5A5, 1'b0, 2'b01, 16'hBEEF, 1'b1, 1'b0};
    vecs[7] = '{2'b00, 2'b00, 4'b0000, 32'h0000_0800, 32'h0000_A5A5, 16'h1111,
                1'b1, 1'b1, 1'b1, 2'b11, 16'h0800, 16'hA5A5, 1'b0, 2'b00, 16'hBEEF, 1'b0, 1'b0};

    reset = 1'b1;
    ifa.req = '0; ifa.wr = '0; ifa.be = '0; ifa.addr = '0; ifa.wdata = '0; ifa.vram_data_in = '0;
    ifb.req = '0; ifb.wr = '0; ifb.be = '0; ifb.addr = '0; ifb.wdata = '0; ifb.vram_data_in = '0;
    ifc.req = '0; ifc.wr = '0; ifc.be = '0; ifc.addr = '0; ifc.wdata = '0; ifc.vram_data_in = '0;
    tick();
    tick();

    // Reset values
    chk("rst en",    32'(ifa._vram_en), 32'h1);
    chk("rst rd",    32'(ifa._vram_rd), 32'h1);
    chk("rst wr",    32'(ifa._vram_wr), 32'h1);
    chk("rst be",    32'(ifa._vram_be), 32'h3);
    chk("rst addr",  32'(ifa.vram_addr), 32'h0);
    chk("rst dout",  32'(ifa.vram_data_out), 32'h0);
    chk("rst oe",    32'(ifa.vram_data_oe), 32'h0);
    chk("rst ack",   32'(ifa.ack), 32'h0);
    chk("rst rdata", 32'(ifa.rdata), 32'h0);
    chk("rst busy",  32'(ifa.busy), 32'h0);
    chk("rst gid",   32'(ifa.grant_id), 32'h0);
    chk("rst gid b", 32'(ifb.grant_id), 32'h0);
    reset = 1'b0;
    tick();

    // Table-driven read and byte-write on A
    for (int i = 0; i < 8; i++) begin
      ifa.req = vecs[i].req;
      ifa.wr = vecs[i].wr;
      ifa.be = vecs[i].be;
      ifa.addr = vecs[i].addr;
      ifa.wdata = vecs[i].wdata;
      ifa.vram_data_in = vecs[i].din;
      tick();
      chk($sformatf("vec%0d en", i),    32'(ifa._vram_en),      32'(vecs[i].en));
      chk($sformatf("vec%0d rd", i),    32'(ifa._vram_rd),      32'(vecs[i].rd));
      chk($sformatf("vec%0d wr", i),    32'(ifa._vram_wr),      32'(vecs[i].wrs));
      chk($sformatf("vec%0d be", i),    32'(ifa._vram_be),      32'(vecs[i].vbe));
      chk($sformatf("vec%0d addr", i),  32'(ifa.vram_addr),     32'(vecs[i].vaddr));
      chk($sformatf("vec%0d dout", i),  32'(ifa.vram_data_out), 32'(vecs[i].dout));
      chk($sformatf("vec%0d oe", i),    32'(ifa.vram_data_oe),  32'(vecs[i].oe));
      chk($sformatf("vec%0d ack", i),   32'(ifa.ack),           32'(vecs[i].ack));
      chk($sformatf("vec%0d rdata", i), 32'(ifa.rdata),         32'(vecs[i].rdata));
      chk($sformatf("vec%0d busy", i),  32'(ifa.busy),          32'(vecs[i].busy));
      chk($sformatf("vec%0d gid", i),   32'(ifa.grant_id),      32'(vecs[i].gid));
    end

    // Fixed priority on A: both request, client 0 wins first. In client 0's
    // ack cycle it is ineligible, so the waiting client 1 is granted there;
    // client 0's re-request is served right after, with no IDLE gap.
    ifa.req = 2'b11; ifa.wr = 2'b00; ifa.addr = 32'h2222_1111;
    tick();
    chk("prio g0 gid", 32'(ifa.grant_id), 32'h0);
    tick();
    tick();
    chk("prio g0 ack", 32'(ifa.ack), 32'h1);
    ifa.req = 2'b10;
    tick();
    chk("prio g1 gid", 32'(ifa.grant_id), 32'h1);
    chk("prio g1 busy", 32'(ifa.busy), 32'h1);
    ifa.req = 2'b11;
    tick();
    tick();
    chk("prio g1 ack", 32'(ifa.ack), 32'h2);
    ifa.req = 2'b01;
    tick();
    chk("prio g2 gid", 32'(ifa.grant_id), 32'h0);
    chk("prio g2 busy", 32'(ifa.busy), 32'h1);
    chk("prio g2 addr", 32'(ifa.vram_addr), 32'h1111);
    tick();
    tick();
    chk("prio g2 ack", 32'(ifa.ack), 32'h1);
    ifa.req = 2'b00;
    tick();
    chk("prio idle", 32'(ifa.busy), 32'h0);

    // Round-robin on B: all three hold req
    ifb.req = 3'b111; ifb.wr = 3'b000;
    n_ack = 0;
    idle_seen = 0;
    got = '{7, 7, 7, 7};
    cyc = '{0, 0, 0, 0};
    for (int c = 1; c <= 30 && n_ack < 4; c++) begin
      tick();
      if (ifb.busy !== 1'b1) idle_seen++;
      if (ifb.ack !== 3'b000) begin
        got[n_ack] = onehot_idx(ifb.ack);
        cyc[n_ack] = c;
        n_ack++;
        if (n_ack == 4) ifb.req = 3'b000;
      end
    end
    chk("rr ack count", 32'(n_ack), 32'd4);
    chk("rr idle gaps", 32'(idle_seen), 32'd0);
    chk("rr first ack cycle", 32'(cyc[0]), 32'd3);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr order%0d", k), 32'(got[k]), 32'(exp_rr[k]));
    for (int k = 1; k < 4; k++)
      chk($sformatf("rr spacing%0d", k), 32'(cyc[k] - cyc[k-1]), 32'd3);
    tick();
    chk("rr idle", 32'(ifb.busy), 32'h0);

    // WAIT_STATES=0 on C: two clients keep req high, one access per 2 cycles
    ifc.req = 2'b11; ifc.wr = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("ws0 en c%0d", c), 32'(ifc._vram_en), (c % 2 == 1) ? 32'h0 : 32'h1);
      chk($sformatf("ws0 ack c%0d", c), 32'(ifc.ack),
          (c % 2 == 1) ? 32'h0 : ((c % 4 == 2) ? 32'h1 : 32'h2));
      if (c == 8) ifc.req = 2'b00;
    end
    tick();
    chk("ws0 idle", 32'(ifc.busy), 32'h0);

    // Reset in the middle of a write access on B
    ifb.req = 3'b010; ifb.wr = 3'b010; ifb.be = 6'b00_11_00;
    ifb.addr = 48'h0000_4321_0000; ifb.wdata = 48'h0000_CAFE_0000;
    tick();
    chk("mid en before", 32'(ifb._vram_en), 32'h0);
    chk("mid oe before", 32'(ifb.vram_data_oe), 32'h1);
    #2 reset = 1'b1;
    ifb.req = 3'b011; ifb.wr = 3'b000;
    #1;
    chk("mid en", 32'(ifb._vram_en), 32'h1);
    chk("mid wr", 32'(ifb._vram_wr), 32'h1);
    chk("mid oe", 32'(ifb.vram_data_oe), 32'h0);
    chk("mid busy", 32'(ifb.busy), 32'h0);
    chk("mid ack", 32'(ifb.ack), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk("post rst ack", 32'(ifb.ack), 32'h0);
    tick();
    chk("post rst gid", 32'(ifb.grant_id), 32'h0);
    chk("post rst ack2", 32'(ifb.ack), 32'h0);
    tick();
    tick();
    chk("post rst ack c0", 32'(ifb.ack), 32'h1);
    ifb.req = 3'b010;
    tick();
    chk("post rst gid1", 32'(ifb.grant_id), 32'h1);
    tick();
    tick();
    chk("post rst ack c1", 32'(ifb.ack), 32'h2);
    ifb.req = 3'b000;
    tick();
    chk("post rst idle", 32'(ifb.busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
